// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and sign helper for the HI/LO multiply/divide unit.
package muldiv_pkg;

  // Widest operand the sign helper handles; callers zero-extend in and truncate out.
  localparam int MAGW = 256;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  // Conditional two's-complement negate; with neg = sign bit this yields the magnitude.
  function automatic logic [MAGW-1:0] twos_mag(input logic [MAGW-1:0] v, input logic neg);
    return neg ? (~v + MAGW'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Unsigned radix-2 restoring divide core: one quotient bit per clock, first bit on load.
module muldiv_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] q_q, r_q, d_q, q_d, r_d, d_d;
  logic [WIDTH-1:0] src_q, src_r;
  logic [WIDTH:0]   trial, diff;
  logic             ge;

  // The core free-runs; the parent samples it exactly WIDTH steps after load.
  always_comb begin
    src_r = load ? '0 : r_q;
    src_q = load ? dividend : q_q;
    d_d   = load ? divisor : d_q;
    trial = {src_r, src_q[WIDTH-1]};
    diff  = trial - {1'b0, d_d};
    ge    = trial >= {1'b0, d_d};
    r_d   = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    q_d   = {src_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_q <= '0;
      r_q <= '0;
      d_q <= '0;
    end else begin
      q_q <= q_d;
      r_q <= r_d;
      d_q <= d_d;
    end
  end

  assign quotient  = q_q;
  assign remainder = r_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO, with start/busy/done handshake.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q, is_div_q, neg_q, rneg_q, bzero_q;
  logic [WIDTH-1:0]   hi_q, lo_q, mcand_q;
  logic [2*WIDTH-1:0] prod_q, prod_ld, prod_fix;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, quo_fix, rem_fix;
  logic               accept, sgn, sa, sb, finish;

  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] up;
    up = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    return {up, p[WIDTH-1:1]};
  endfunction

  assign accept = start && !busy_q && !flush;
  assign sgn    = (op == OP_MULT) || (op == OP_DIV);
  assign sa     = sgn & a[WIDTH-1];
  assign sb     = sgn & b[WIDTH-1];
  assign mag_a  = WIDTH'(twos_mag(MAGW'(a), sa));
  assign mag_b  = WIDTH'(twos_mag(MAGW'(b), sb));

`ifdef MULDIV_FAST_MUL_EN
  assign prod_ld = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
  assign finish  = !is_div_q || (cnt_q == CW'(WIDTH));
`else
  // The first shift-add step happens on the accept edge, so WIDTH-1 remain in RUN.
  assign prod_ld = mul_step({{WIDTH{1'b0}}, mag_b}, mag_a);
  assign finish  = (cnt_q == CW'(WIDTH));
`endif

  muldiv_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .load      (accept),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quo),
    .remainder (rem)
  );

  // Divide-by-zero: the restoring core already leaves |a| in the remainder.
  assign prod_fix = (2*WIDTH)'(twos_mag(MAGW'(prod_q), neg_q));
  assign quo_fix  = bzero_q ? '1 : WIDTH'(twos_mag(MAGW'(quo), neg_q));
  assign rem_fix  = WIDTH'(twos_mag(MAGW'(rem), rneg_q));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state_q  <= ST_RUN;
                busy_q   <= 1'b1;
                cnt_q    <= CW'(1);
                is_div_q <= op[1];
                neg_q    <= sa ^ sb;
                rneg_q   <= sa;
                bzero_q  <= (b == '0);
                mcand_q  <= mag_a;
                prod_q   <= prod_ld;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (finish) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end else begin
            cnt_q  <= cnt_q + CW'(1);
            prod_q <= mul_step(prod_q, mcand_q);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk, resetn, start, flush, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  int          checks = 0;
  int          failures = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      OP_MULTU: return {32'b0, x} * {32'b0, y};
      OP_MULT:  return 64'(sx * sy);
      OP_DIVU:  if (y == 0) return {x, 32'hFFFFFFFF}; else return {x % y, x / y};
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o);
    return (FAST && (o == OP_MULT || o == OP_MULTU)) ? 1 : 32;
  endfunction

  // Called at a negedge; returns at the negedge where done is high (or after the bound).
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] e);
    int lat;
    lat = 0;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 3));
    chk({tag, "_busy_accept"}, 64'(busy), 64'd1);
    for (int i = 1; i <= 80 && lat == 0; i++) begin
      @(negedge clk);
      if (done) lat = i;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat(o)));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, e);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic        seen;

    resetn = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    @(negedge clk);
    chk("reset_state", {hi, lo, 30'b0, busy, done}, 96'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 64'h00000005_FFFFFFFF);
    run_op("div_zero", OP_DIV, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF);

    // MTHI / MTLO never raise busy or done
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1; op = OP_MTHI; a = 32'h1234;
    @(negedge clk);
    seen |= busy | done;
    op = OP_MTLO; a = 32'h5678;
    @(negedge clk);
    seen |= busy | done;
    start = 1'b0;
    repeat (2) begin @(negedge clk); seen |= busy | done; end
    chk("mthi_mtlo_hilo", {hi, lo}, 64'h00001234_00005678);
    chk("mthi_mtlo_quiet", 64'(seen), 64'd0);

    // reserved op code leaves everything alone
    start = 1'b1; op = 3'd6; a = 32'hDEAD; b = 32'hBEEF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("reserved_op", {hi, lo, 30'b0, busy, done}, {64'h00001234_00005678, 32'b0});

    // start while busy is dropped; original DIV result is delivered
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 80 && !seen; i++) begin
      if (i == 3) begin start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3; end
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        chk("ignored_start_latency", 64'(i), 64'd32);
      end
    end
    chk("ignored_start_seen", 64'(seen), 64'd1);
    chk("ignored_start_hilo", {hi, lo}, 64'h00000002_0000000E);

    // flush at cycle 10 of a DIV
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'hFFFFFFCE; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1; start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= done | busy; end
    chk("flush_no_done", 64'(seen), 64'd0);
    chk("flush_hilo", {hi, lo}, 64'h00000002_0000000E);

    // asynchronous reset mid-DIV
    start = 1'b1; op = OP_DIVU; a = 32'd77; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk("async_reset", {hi, lo, 30'b0, busy, done}, 96'(0));
    @(negedge clk);
    resetn = 1'b1;
    run_op("multu_after_reset", OP_MULTU, 32'd2, 32'd3, 64'd6);

    // randomized back-to-back ops (each start lands in the done cycle)
    for (int n = 0; n < 24; n++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op("random", ro, ra, rb, model(ro, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
